// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//
// Shares one single-port Gowin BSRAM (Gowin_SP: ce/oce/wre/ad/din/dout) between
// two independent requesters A and B. Round-robin arbitration issues at most one
// BRAM command per cycle. Read tags travel alongside the BRAM latency, so each
// read response returns to the requester that issued the read.
//
// Optional build macro:
//   BRAM_INIT_EN  - after reset, sweep INIT_VALUE into every BRAM address
//                   (busy=1, no grants) before normal operation starts.
//
// Parameters:
//   AW         BRAM address width
//   DW         BRAM data width
//   RD_LAT     cycles from BRAM command cycle to valid dout (legal 1..4)
//   INIT_VALUE fill value for the init sweep (used only with BRAM_INIT_EN)
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata  (in)     requester A command, held until a_gnt
//   a_gnt, a_rvalid            (out)    A accepted this cycle / A read data valid
//   b_*                                 same as A, for requester B
//   rdata                      (out)    shared read data, qualified by x_rvalid
//   busy                       (out)    init sweep in progress
//   bram_ce/oce/wre/ad/din     (out)    BRAM command port
//   bram_dout                  (in)     BRAM read data
// -----------------------------------------------------------------------------
module bram_arbiter #(
  parameter int            AW         = 3,
  parameter int            DW         = 8,
  parameter int            RD_LAT     = 2,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          bram_ce,
  output logic          bram_oce,
  output logic          bram_wre,
  output logic [AW-1:0] bram_ad,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef BRAM_INIT_EN
  localparam logic [0:0] ST_RESET = ST_INIT;
`else
  localparam logic [0:0] ST_RESET = ST_RUN;
`endif

  logic [0:0]        r_state;
  logic [AW-1:0]     r_init_addr;
  logic              r_prio_b;      // 1: B wins a tie (A was granted last)
  logic              r_bram_wre;
  logic [AW-1:0]     r_bram_ad;
  logic [DW-1:0]     r_bram_din;
  logic [RD_LAT-1:0] r_tag_v;       // read in flight at this pipeline stage
  logic [RD_LAT-1:0] r_tag_b;       // 1: that read belongs to B
  logic              r_a_rvalid;
  logic              r_b_rvalid;

  logic              w_run;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_gnt;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_wdata;

  assign w_run = (r_state == ST_RUN);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (w_run) begin
      if (a_req && (!b_req || !r_prio_b)) begin
        w_a_gnt = 1'b1;
      end else if (b_req) begin
        w_b_gnt = 1'b1;
      end
    end
  end

  assign w_gnt   = w_a_gnt | w_b_gnt;
  assign w_we    = w_b_gnt ? b_we    : a_we;
  assign w_addr  = w_b_gnt ? b_addr  : a_addr;
  assign w_wdata = w_b_gnt ? b_wdata : a_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= r_init_addr + 1'b1;
      if (r_init_addr == '1) begin
        r_state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_b <= 1'b0;
    end else if (w_a_gnt) begin
      r_prio_b <= 1'b1;
    end else if (w_b_gnt) begin
      r_prio_b <= 1'b0;
    end
  end

  // Command register: address/data hold when idle, only wre drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bram_wre <= 1'b0;
      r_bram_ad  <= '0;
      r_bram_din <= '0;
    end else if (r_state == ST_INIT) begin
      r_bram_wre <= 1'b1;
      r_bram_ad  <= r_init_addr;
      r_bram_din <= INIT_VALUE;
    end else if (w_gnt) begin
      r_bram_wre <= w_we;
      r_bram_ad  <= w_addr;
      r_bram_din <= w_wdata;
    end else begin
      r_bram_wre <= 1'b0;
    end
  end

  // Read tags enter together with the command and reach the output register
  // exactly when the BRAM output register presents the data. Clearing them on
  // reset is what discards reads that were in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v    <= '0;
      r_tag_b    <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_tag_v[0] <= w_gnt & ~w_we;
      r_tag_b[0] <= w_b_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_b[i] <= r_tag_b[i-1];
      end
      r_a_rvalid <= r_tag_v[RD_LAT-1] & ~r_tag_b[RD_LAT-1];
      r_b_rvalid <= r_tag_v[RD_LAT-1] &  r_tag_b[RD_LAT-1];
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  // dout is only meaningful in a response cycle; gate it so rdata is 0 otherwise.
  assign rdata    = (r_a_rvalid | r_b_rvalid) ? bram_dout : '0;

`ifdef BRAM_INIT_EN
  assign busy     = (r_state == ST_INIT);
`else
  assign busy     = 1'b0;
`endif

  assign bram_ce  = 1'b1;
  assign bram_oce = 1'b1;
  assign bram_wre = r_bram_wre;
  assign bram_ad  = r_bram_ad;
  assign bram_din = r_bram_din;

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
//
// Self-checking bench for bram_arbiter with a behavioural Gowin_SP model.
// Every grant is observed; writes update a shadow memory, reads push the
// expected (requester, data, response cycle) into a scoreboard that is popped
// when a_rvalid/b_rvalid appear. Build with +define+BRAM_INIT_EN to also cover
// the init sweep.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;

  localparam int         AW       = 3;
  localparam int         DW       = 8;
  localparam int         RD_LAT   = 2;
  localparam logic [7:0] INIT_VAL = 8'h5A;

  typedef struct {
    logic       is_b;
    logic [7:0] data;
    int         cyc;
  } rd_t;

  logic          clk;
  logic          rst_n;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          bram_ce, bram_oce, bram_wre;
  logic [AW-1:0] bram_ad;
  logic [DW-1:0] bram_din, bram_dout;

  bram_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .INIT_VALUE(INIT_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .busy(busy),
    .bram_ce(bram_ce), .bram_oce(bram_oce), .bram_wre(bram_wre),
    .bram_ad(bram_ad), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Gowin_SP model: core register then oce output register (RD_LAT stages).
  logic [7:0] mem  [8];
  logic [7:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_wre) mem[bram_ad] <= bram_din;
      pipe[0] <= mem[bram_ad];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bram_dout = pipe[RD_LAT-1];

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] shadow [8];
  rd_t        sb [$];
  logic       gnt_log [$];
  int         gnt_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Grant / response monitor, sampled mid-cycle.
  logic       m_we;
  logic [2:0] m_addr;
  logic [7:0] m_wd;
  rd_t        m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_gnt || b_gnt) begin
        check("gnt_onehot", 32'(a_gnt & b_gnt), 32'(0));
        check("gnt_has_req", 32'((a_gnt & ~a_req) | (b_gnt & ~b_req)), 32'(0));
        check("ce_oce", 32'({bram_ce, bram_oce}), 32'(3));
        m_we   = b_gnt ? b_we    : a_we;
        m_addr = b_gnt ? b_addr  : a_addr;
        m_wd   = b_gnt ? b_wdata : a_wdata;
        gnt_log.push_back(b_gnt);
        gnt_cyc.push_back(cyc);
        if (m_we) begin
          shadow[m_addr] = m_wd;
        end else begin
          m_e.is_b = b_gnt;
          m_e.data = shadow[m_addr];
          m_e.cyc  = cyc + 1 + RD_LAT;
          sb.push_back(m_e);
        end
      end
      if (a_rvalid || b_rvalid) begin
        if (sb.size() == 0) begin
          check("rvalid_unexpected", 32'({a_rvalid, b_rvalid}), 32'(0));
        end else begin
          m_e = sb.pop_front();
          check("rvalid_id", 32'({a_rvalid, b_rvalid}), m_e.is_b ? 32'(1) : 32'(2));
          check("rdata", 32'(rdata), 32'(m_e.data));
          check("rd_latency", 32'(cyc), 32'(m_e.cyc));
        end
      end
    end
  end

  // Present one request and hold it until granted; returns just after the
  // edge that accepted it, so calls chain back-to-back.
  task automatic req(input logic is_b, input logic we, input logic [2:0] addr,
                     input logic [7:0] wd);
    bit got = 0;
    if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_b ? b_gnt : a_gnt) begin got = 1; break; end
    end
    if (!got) check(is_b ? "b_gnt_timeout" : "a_gnt_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    if (is_b) b_req = 0; else a_req = 0;
  endtask

  task automatic drain();
    repeat (RD_LAT + 4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit hold_a);
    a_req = 0; b_req = 0;
    @(posedge clk); #1;
    rst_n = 0;
    sb.delete();
    #1;
    check("rst_wre", 32'(bram_wre), 32'(0));
    check("rst_ad", 32'(bram_ad), 32'(0));
    check("rst_din", 32'(bram_din), 32'(0));
    check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
`ifdef BRAM_INIT_EN
    check("rst_busy", 32'(busy), 32'(1));
`else
    check("rst_busy", 32'(busy), 32'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
`ifdef BRAM_INIT_EN
    for (int k = 0; k < 8; k++) shadow[k] = INIT_VAL;
    if (hold_a) begin a_req = 1; a_we = 0; a_addr = 3'd6; a_wdata = 8'h00; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("init_busy", 32'(busy), 32'(1));
      check("init_no_gnt", 32'({a_gnt, b_gnt}), 32'(0));
      if (i > 0) begin
        check("init_wre", 32'(bram_wre), 32'(1));
        check("init_ad", 32'(bram_ad), 32'(i - 1));
        check("init_din", 32'(bram_din), 32'(INIT_VAL));
      end
    end
    @(negedge clk);
    check("init_done_busy", 32'(busy), 32'(0));
    check("init_last_ad", 32'(bram_ad), 32'(7));
    if (hold_a) check("init_held_gnt", 32'(a_gnt), 32'(1));
`else
    @(negedge clk);
    check("run_busy", 32'(busy), 32'(0));
`endif
    @(posedge clk); #1;
    a_req = 0;
    gnt_log.delete();
    gnt_cyc.delete();
  endtask

  initial begin
    rst_n = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    do_reset(1'b1);

`ifdef BRAM_INIT_EN
    // Every location must read back the fill value.
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 3'(i), 8'h00);
    drain();
`endif

    // Preload: addr i holds {i,i} (addr 1 = 8'h11, addr 5 = 8'h55).
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 3'(i), 8'(i * 17));
    drain();

    // Single write then read by A on consecutive cycles.
    gnt_cyc.delete();
    req(1'b0, 1'b1, 3'd2, 8'hAA);
    req(1'b0, 1'b0, 3'd2, 8'h00);
    check("wr_rd_consecutive", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'(1));
    drain();

    // Contention after reset: A first, then strict alternation.
    do_reset(1'b0);
    fork
      repeat (4) req(1'b0, 1'b0, 3'd1, 8'h00);
      repeat (4) req(1'b1, 1'b0, 3'd5, 8'h00);
    join
    check("alt_count", 32'(gnt_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      check("alt_order", 32'(gnt_log[i]), 32'(i % 2));
    drain();

    // Back-to-back reads by B alone.
    gnt_log.delete(); gnt_cyc.delete();
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 3'(i), 8'h00);
    for (int i = 0; i < 8 && i < gnt_cyc.size(); i++) begin
      check("b2b_id", 32'(gnt_log[i]), 32'(1));
      check("b2b_cycle", 32'(gnt_cyc[i] - gnt_cyc[0]), 32'(i));
    end
    drain();

    // Write/read ordering, A wins (last grant was B): B reads the new data.
    gnt_log.delete();
    fork
      req(1'b0, 1'b1, 3'd3, 8'hC3);
      req(1'b1, 1'b0, 3'd3, 8'h00);
    join
    check("wr_first_order", 32'({gnt_log[0], gnt_log[1]}), 32'(2'b01));
    check("wr_first_shadow", 32'(shadow[3]), 32'(8'hC3));
    drain();

    // Ordering with B winning (A granted last): B reads the old data.
    req(1'b0, 1'b0, 3'd0, 8'h00);
    gnt_log.delete();
    fork
      req(1'b0, 1'b1, 3'd4, 8'hC4);
      req(1'b1, 1'b0, 3'd4, 8'h00);
    join
    check("rd_first_order", 32'({gnt_log[0], gnt_log[1]}), 32'(2'b10));
    drain();

    // Reset one cycle before A's read data is due: the response must vanish,
    // and the pointer must favour A again.
    req(1'b0, 1'b0, 3'd7, 8'h00);
    do_reset(1'b0);
    repeat (RD_LAT + 3) @(posedge clk);
    #1;
    fork
      req(1'b0, 1'b0, 3'd1, 8'h00);
      req(1'b1, 1'b0, 3'd5, 8'h00);
    join
    check("post_rst_order", 32'({gnt_log[0], gnt_log[1]}), 32'(2'b01));
    drain();

    // Mixed random traffic from both requesters.
    fork
      for (int k = 0; k < 30; k++) begin
        req(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int k = 0; k < 30; k++) begin
        req(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port BSRAM instance (Gowin_SP: ce/oce/wre/ad/din/dout) between two independent requesters, A and B.
- Performs round-robin arbitration and issues at most one access per cycle to the BRAM port.
- Tracks read latency through the BRAM output register and returns read data to the requester that issued the read.
- Sits between the Gowin_SP instance and user logic, such as a writer FSM and a reader/display path.

Parameters:
- AW, 3: BRAM address width.
- DW, 8: BRAM data width.
- RD_LAT, 2: cycles from BRAM command cycle to valid dout. Covers the BRAM core register plus the oce output register; legal range 1..4.
- INIT_VALUE, 8'h00: fill value written by the init sweep; only used with BRAM_INIT_EN.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A access request; held until a_gnt
- a_we  in  1  A: 1=write, 0=read; valid with a_req
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_gnt  out  1  A request accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid on rdata
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  same as A, for requester B
- rdata  out  DW  read data, shared; qualified by a_rvalid/b_rvalid
- busy  out  1  init sweep in progress; no grants issued
- bram_ce  out  1  BRAM clock enable
- bram_oce  out  1  BRAM output-register enable
- bram_wre  out  1  BRAM write enable
- bram_ad  out  AW  BRAM address
- bram_din  out  DW  BRAM write data
- bram_dout  in  DW  BRAM read data

Behaviour:
- Reset values (async on rst_n=0):
  - bram_wre=0, bram_ad=0, bram_din=0.
  - a_rvalid=b_rvalid=0, rdata=0.
  - Round-robin pointer favours A.
  - Latency pipeline cleared.
  - busy=1 if BRAM_INIT_EN is defined, else 0.
- bram_ce=1 and bram_oce=1 at all times outside reset.
- FSM states are INIT and RUN. Without BRAM_INIT_EN the reset state is RUN.
- Arbitration (RUN only, cycle T, combinational):
  - Only one requesting: grant it.
  - Both requesting: grant the one not granted most recently. The pointer updates on every grant.
  - At most one gnt is high per cycle; no gnt without the matching req.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt high at a rising edge.
  - It may present a new request in the next cycle, so back-to-back grants to the same requester are allowed when the other is idle.
- Command issue:
  - At the edge ending cycle T, the granted we/addr/wdata are registered onto bram_wre/bram_ad/bram_din.
  - The BRAM sees the command in cycle T+1.
  - If there is no grant, bram_wre=0 and bram_ad/bram_din hold their values.
- Reads:
  - A tag (valid, requester id) enters an RD_LAT-deep shift register with the command.
  - In cycle T+1+RD_LAT, the matching x_rvalid=1 for one cycle and rdata=bram_dout.
  - Reads retire in issue order. Up to RD_LAT reads are in flight; there is no stall.
- Writes produce no response.
  - A read issued to the same address in the cycle after a write returns the new data (BRAM write-first is not required, since the accesses are sequential commands).
- Throughput: one access per cycle sustained. With both requesters always active, grants alternate A,B,A,B.
- Reset mid-operation: in-flight reads are discarded, no rvalid is produced for them, and the pointer returns to favour A.

Optional Feature:
- Macro: BRAM_INIT_EN.
- Defined:
  - After rst_n deasserts, the FSM is in INIT with busy=1, all gnt=0 and requests ignored (held).
  - It writes INIT_VALUE to addresses 0..2^AW-1, one per cycle, with bram_wre=1.
  - After the last address it enters RUN the next cycle and busy drops to 0.
  - The sweep takes exactly 2^AW cycles (8 at default).
- Not defined: busy tied 0, the FSM starts in RUN, and INIT_VALUE is unused.

Test Plan:
- Single write then read, A: write addr 2 = 8'hAA granted in cycle T; read addr 2 granted in T+1 -> a_rvalid=1 with rdata=8'hAA in cycle T+2+RD_LAT (T+4 at default); b_rvalid stays 0.
- Contention: a_req and b_req held high continuously, reads of addr 1 (A) and addr 5 (B) preloaded with 8'h11/8'h55 -> grants alternate A,B,A,B starting with A after reset; rvalid/rdata alternate 8'h11, 8'h55 in order.
- Back-to-back: B alone issues 8 reads of addresses 0..7 on consecutive cycles -> b_gnt high for 8 consecutive cycles; b_rvalid high for 8 consecutive cycles RD_LAT+1 cycles later, with data in address order.
- Reset mid-flight: A read granted, rst_n pulsed low 1 cycle before data is due -> no a_rvalid afterwards; after reset, simultaneous requests grant A first.
- BRAM_INIT_EN, INIT_VALUE=8'h5A: after reset, busy=1 for 8 cycles with bram_wre=1 and bram_ad=0..7; a_req held meanwhile gets no gnt until busy=0; subsequent reads of all 8 addresses return 8'h5A.
- Write/read ordering: A writes addr 3 = 8'hC3 in cycle T while B has a read of addr 3 pending -> if A wins, B's rdata=8'hC3; verify against the grant order.
